// File: rtl/reg_write_demux_file_pkg.sv
// rtl/reg_write_demux_file_pkg.sv - shared widths and register indices for the register file
package reg_write_demux_file_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;

  localparam logic [ADDR_W-1:0] R0 = 3'd0;
  localparam logic [ADDR_W-1:0] R1 = 3'd1;
  localparam logic [ADDR_W-1:0] R2 = 3'd2;
  localparam logic [ADDR_W-1:0] R3 = 3'd3;
  localparam logic [ADDR_W-1:0] R4 = 3'd4;
  localparam logic [ADDR_W-1:0] R5 = 3'd5;
  localparam logic [ADDR_W-1:0] R6 = 3'd6;
  localparam logic [ADDR_W-1:0] R7 = 3'd7;

endpackage

// File: rtl/reg_write_demux_file_decoder.sv
// rtl/reg_write_demux_file_decoder.sv - gate-level 3-to-8 one-hot write decoder
module write_decoder_3to8
  import reg_write_demux_file_pkg::*;
(
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              EN,
  output logic [NREGS-1:0]  Y
);

  // Enable folds into every minterm so a disabled write selects nothing
  assign Y[0] = EN & ~ADDR[2] & ~ADDR[1] & ~ADDR[0];
  assign Y[1] = EN & ~ADDR[2] & ~ADDR[1] &  ADDR[0];
  assign Y[2] = EN & ~ADDR[2] &  ADDR[1] & ~ADDR[0];
  assign Y[3] = EN & ~ADDR[2] &  ADDR[1] &  ADDR[0];
  assign Y[4] = EN &  ADDR[2] & ~ADDR[1] & ~ADDR[0];
  assign Y[5] = EN &  ADDR[2] & ~ADDR[1] &  ADDR[0];
  assign Y[6] = EN &  ADDR[2] &  ADDR[1] & ~ADDR[0];
  assign Y[7] = EN &  ADDR[2] &  ADDR[1] &  ADDR[0];

endmodule

// File: rtl/reg_write_demux_file.sv
// rtl/reg_write_demux_file.sv - 8x8 register file with one-hot write demux and two read ports
module reg_write_demux_file #(
  parameter int DATA_W = reg_write_demux_file_pkg::DATA_W,
  parameter int ADDR_W = reg_write_demux_file_pkg::ADDR_W,
  parameter int NREGS  = reg_write_demux_file_pkg::NREGS
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              WRITE_DONE,
  output logic [ADDR_W-1:0] LAST_WADDR
);

  logic [NREGS-1:0]  wsel;
  logic [DATA_W-1:0] regs [NREGS];

  write_decoder_3to8 u_wdec (
    .ADDR (INADDRESS),
    .EN   (WRITE),
    .Y    (wsel)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wsel[i]) regs[i] <= IN;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      WRITE_DONE <= 1'b0;
      LAST_WADDR <= '0;
    end else begin
      WRITE_DONE <= WRITE;
      if (WRITE) LAST_WADDR <= INADDRESS;
    end
  end

  // No bypass: a same-cycle read of the write target sees the old value
  assign OUT1 = regs[OUT1ADDRESS];
  assign OUT2 = regs[OUT2ADDRESS];

endmodule

// File: tb/tb_reg_write_demux_file.sv
// tb/tb_reg_write_demux_file.sv - randomized self-checking bench for reg_write_demux_file
module tb_reg_write_demux_file;
  import reg_write_demux_file_pkg::*;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [DATA_W-1:0] IN = '0;
  logic [ADDR_W-1:0] INADDRESS = '0;
  logic              WRITE = 1'b0;
  logic [ADDR_W-1:0] OUT1ADDRESS = '0;
  logic [ADDR_W-1:0] OUT2ADDRESS = '0;
  logic [DATA_W-1:0] OUT1, OUT2;
  logic              WRITE_DONE;
  logic [ADDR_W-1:0] LAST_WADDR;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  logic [DATA_W-1:0] m_regs [NREGS];
  logic              m_done = 1'b0;
  logic [ADDR_W-1:0] m_last = '0;

  reg_write_demux_file dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IN          (IN),
    .INADDRESS   (INADDRESS),
    .WRITE       (WRITE),
    .OUT1ADDRESS (OUT1ADDRESS),
    .OUT2ADDRESS (OUT2ADDRESS),
    .OUT1        (OUT1),
    .OUT2        (OUT2),
    .WRITE_DONE  (WRITE_DONE),
    .LAST_WADDR  (LAST_WADDR)
  );

  always #5 CLK = ~CLK;

  // Reference: memory array written on commit, cleared by reset
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] <= '0;
      m_done <= 1'b0;
      m_last <= '0;
    end else begin
      if (WRITE) begin
        m_regs[INADDRESS] <= IN;
        m_last <= INADDRESS;
      end
      m_done <= WRITE;
    end
  end

  always @(posedge CLK) begin
    if (!RESET && WRITE)
      assert (!$isunknown(INADDRESS)) else $error("INADDRESS unknown during write");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("model_out1", 32'(OUT1), 32'(m_regs[OUT1ADDRESS]));
      check("model_out2", 32'(OUT2), 32'(m_regs[OUT2ADDRESS]));
      check("model_done", 32'(WRITE_DONE), 32'(m_done));
      check("model_last", 32'(LAST_WADDR), 32'(m_last));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #12;
    RESET = 1'b0;
    tick();
    cmp_en = 1'b1;

    // Async reset clears a written register without a clock edge
    WRITE = 1'b1; INADDRESS = R3; IN = 8'h5A;
    tick();
    WRITE = 1'b0; OUT1ADDRESS = R3;
    #1;
    check("t1_pre_reset", 32'(OUT1), 32'h5A);
    RESET = 1'b1;
    #1;
    check("t1_out1_async", 32'(OUT1), 32'h00);
    check("t1_done", 32'(WRITE_DONE), 32'h0);
    check("t1_last", 32'(LAST_WADDR), 32'h0);
    #3;
    RESET = 1'b0;
    tick();

    // Basic write and one-cycle done pulse
    WRITE = 1'b1; INADDRESS = R5; IN = 8'h7F; OUT1ADDRESS = R5;
    tick();
    WRITE = 1'b0;
    check("t2_out1", 32'(OUT1), 32'h7F);
    check("t2_done", 32'(WRITE_DONE), 32'h1);
    check("t2_last", 32'(LAST_WADDR), 32'h5);
    for (int i = 0; i < NREGS; i++) begin
      if (i != 5) begin
        OUT2ADDRESS = 3'(i);
        #1;
        check("t2_other_zero", 32'(OUT2), 32'h0);
      end
    end
    tick();
    check("t2_done_drop", 32'(WRITE_DONE), 32'h0);

    // Disabled write never lands
    WRITE = 1'b0; INADDRESS = R2; IN = 8'hFF; OUT1ADDRESS = R2;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_done", 32'(WRITE_DONE), 32'h0);
      check("t3_r2", 32'(OUT1), 32'h0);
    end

    // Read-during-write shows old value until the edge
    WRITE = 1'b1; INADDRESS = R1; IN = 8'h10;
    tick();
    OUT2ADDRESS = R1; IN = 8'h22;
    #1;
    check("t4_old", 32'(OUT2), 32'h10);
    tick();
    WRITE = 1'b0;
    check("t4_new", 32'(OUT2), 32'h22);

    // Back-to-back sweep
    for (int i = 0; i < NREGS; i++) begin
      WRITE = 1'b1; INADDRESS = 3'(i); IN = 8'(i + 1);
      tick();
      check("t5_done_run", 32'(WRITE_DONE), 32'h1);
    end
    WRITE = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      OUT1ADDRESS = 3'(i); OUT2ADDRESS = 3'(i);
      #1;
      check("t5_out1", 32'(OUT1), 32'(i + 1));
      check("t5_out2", 32'(OUT2), 32'(i + 1));
    end
    tick();

    // Reset straddling a write edge drops that write
    WRITE = 1'b1; IN = 8'hC3; INADDRESS = R6; OUT1ADDRESS = R6;
    #1;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("t6_r6_lost", 32'(OUT1), 32'h0);
    check("t6_done", 32'(WRITE_DONE), 32'h0);
    tick();
    WRITE = 1'b0;
    check("t6_r6_commit", 32'(OUT1), 32'hC3);
    check("t6_done_after", 32'(WRITE_DONE), 32'h1);
    check("t6_last", 32'(LAST_WADDR), 32'h6);

    // Random traffic with occasional async reset pulses
    for (int n = 0; n < 400; n++) begin
      WRITE       = ($urandom_range(0, 3) != 0);
      INADDRESS   = 3'($urandom_range(0, 7));
      IN          = 8'($urandom);
      OUT1ADDRESS = 3'($urandom_range(0, 7));
      OUT2ADDRESS = ($urandom_range(0, 3) == 0) ? INADDRESS : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) begin
        #1 RESET = 1'b1;
        #1 RESET = 1'b0;
      end
      tick();
    end

    WRITE = 1'b0;
    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_write_demux_file.md
Name: reg_write_demux_file

Overview:
- 8 x 8-bit register file for the 8-bit single-cycle processor, built around a one-hot write demultiplexer.
- Forms the write end of the operand-select path: the ALU result (or immediate) coming out of the datapath muxes is steered by a 3-bit address into exactly one register.
- Two independent read ports supply ALU operand A and B.
- Sits between the control unit/ALU result bus and the ALU operand muxes.

Parameters:
- DATA_W, 8, register and data width in bits.
- ADDR_W, 3, register address width.
- NREGS, 8, number of registers; must equal 2**ADDR_W.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- IN  input  DATA_W  write data (ALU result bus).
- INADDRESS  input  ADDR_W  destination register select.
- WRITE  input  1  write enable from control unit.
- OUT1ADDRESS  input  ADDR_W  read port 1 register select.
- OUT2ADDRESS  input  ADDR_W  read port 2 register select.
- OUT1  output  DATA_W  read port 1 data.
- OUT2  output  DATA_W  read port 2 data.
- WRITE_DONE  output  1  registered one-cycle pulse; a write committed on the previous rising edge.
- LAST_WADDR  output  ADDR_W  address of the most recent committed write.

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset: while RESET=1, all NREGS registers, WRITE_DONE and LAST_WADDR are forced to 0 immediately, independent of CLK. OUT1 and OUT2 therefore read 0.
- Write demux: INADDRESS is decoded to a one-hot vector wsel[NREGS-1:0]. The decode is gated by WRITE, so wsel is all zeros when WRITE=0.
- Write commit: on a CLK rising edge with RESET=0, register i loads IN iff wsel[i]=1. All other registers hold. At most one register changes per edge.
- Write latency: one edge. Data presented before edge k is readable after edge k.
- Reads: OUT1 = reg[OUT1ADDRESS] and OUT2 = reg[OUT2ADDRESS], purely combinational. No read enable.
- Read-during-write to the same address in the same cycle: the read port shows the OLD value until the edge, then the new value. No internal bypass; the pipeline does not need one.
- Both read ports may address the same register. Both read ports may address the write target.
- WRITE_DONE: registered. It is 1 for exactly the cycle after an edge where WRITE=1, otherwise 0. Back-to-back writes hold it high continuously.
- LAST_WADDR: updates to INADDRESS on every committing edge. It holds otherwise.
- Reset mid-operation: if RESET asserts while WRITE=1, the pending write is lost. Registers, WRITE_DONE and LAST_WADDR read 0.
- Reset deassertion: the first edge with RESET=0 commits normally if WRITE=1.
- X on INADDRESS while WRITE=0 has no effect. X on INADDRESS while WRITE=1 is a control-unit bug; the testbench flags it with an assertion.
- No wrap-around or overflow conditions: the address space is fully decoded, so every INADDRESS value is legal.

Decomposition:
- Shared package holds:
  - DATA_W, ADDR_W, NREGS constants.
  - Named register indices R0..R7, used by the testbench and control unit.
- Sub-module write_decoder_3to8 (gate-level): inputs ADDR[2:0] and EN, output one-hot Y[7:0]. It is instantiated once for the write path.
- Read selection reuses the team's existing 8-bit multiplexer cells as a mux tree per read port, or an equivalent indexed read.

Test Plan:
1. Reset: pulse RESET asynchronously mid-cycle after writing 0x5A to R3 -> OUT1 (OUT1ADDRESS=3) drops to 0x00 immediately without a clock edge; WRITE_DONE=0; LAST_WADDR=0.
2. Basic write/read: WRITE=1, INADDRESS=5, IN=0x7F, one edge -> OUT1 (addr 5)=0x7F; WRITE_DONE=1 for one cycle; LAST_WADDR=5; all other registers remain 0x00.
3. Write disabled: WRITE=0, INADDRESS=2, IN=0xFF, three edges -> R2 stays 0x00 and WRITE_DONE stays 0.
4. Read-during-write: R1=0x10; in the same cycle set OUT2ADDRESS=1, WRITE=1, INADDRESS=1, IN=0x22 -> OUT2=0x10 before the edge and 0x22 after it.
5. Back-to-back sweep: write 0x01..0x08 to R0..R7 on consecutive edges -> WRITE_DONE high for 8 consecutive cycles; final readback on both ports matches every value; OUT1 and OUT2 are both correct with the same address.
6. Reset during write: WRITE=1, IN=0xC3, INADDRESS=6, assert RESET before the edge and release it after the edge -> R6=0x00, WRITE_DONE=0. The next edge with WRITE=1 stores 0xC3 normally.
